// File: rtl/ifetch_responder.sv
// ifetch_responder
//   Read-only memory client serving instruction fetches from the icache.
//   A request latches the pc, issues four consecutive byte reads to RAM and
//   assembles them little-endian into one 32-bit word.
//   The word is returned with a one-cycle ready pulse.
//   The pc is the full 32-bit value, so any pc change mid-fetch aborts it.
//   RAM addresses wrap modulo 2^RAM_ADDR_WIDTH.
//
// Parameters
//   RAM_ADDR_WIDTH   number of valid byte-address bits driven on mem_a
//
// Optional feature
//   IFETCH_LAST_WORD_EN  when defined, keeps a one-entry {valid, pc, inst}
//                        buffer. A repeat request for the buffered pc is
//                        answered on the next edge without touching RAM.
//
// Ports
//   clk_in            clock, rising edge active
//   rst_in            asynchronous active-low reset
//   rdy_in            global enable; low freezes all state and outputs
//   ic_to_mc_request  fetch request (level)
//   ic_to_mc_pc       byte address of the requested instruction
//   mc_to_ic_ready    one-cycle pulse: mc_to_ic_inst is valid
//   mc_to_ic_inst     fetched instruction word (registered, held)
//   mem_din           RAM read data for the address on mem_a
//   mem_a             RAM byte address
//   mem_wr            RAM write strobe, always 0
module ifetch_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_to_mc_request,
  input  logic [31:0] ic_to_mc_pc,
  output logic        mc_to_ic_ready,
  output logic [31:0] mc_to_ic_inst,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [31:0] ADDR_MASK = (RAM_ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << RAM_ADDR_WIDTH) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [1:0]  issue_cnt;
  logic [2:0]  cap_cnt;
  logic [23:0] asm_q;   // bytes 0..2 of the word in flight

`ifdef IFETCH_LAST_WORD_EN
  logic        lw_valid;
  logic [31:0] lw_pc;
  logic [31:0] lw_inst;
`endif

  // Masking the full sum is equivalent to adding within RAM_ADDR_WIDTH bits.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [1:0]  off);
    logic [31:0] sum;
    sum = base + {30'd0, off};
    return sum & ADDR_MASK;
  endfunction

  assign mem_wr = 1'b0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      pc_q           <= '0;
      issue_cnt      <= '0;
      cap_cnt        <= '0;
      asm_q          <= '0;
      mem_a          <= '0;
      mc_to_ic_ready <= 1'b0;
      mc_to_ic_inst  <= '0;
`ifdef IFETCH_LAST_WORD_EN
      lw_valid       <= 1'b0;
      lw_pc          <= '0;
      lw_inst        <= '0;
`endif
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          mc_to_ic_ready <= 1'b0;
          issue_cnt      <= '0;
          cap_cnt        <= '0;
          if (ic_to_mc_request) begin
`ifdef IFETCH_LAST_WORD_EN
            if (lw_valid && (ic_to_mc_pc == lw_pc)) begin
              // Buffer hit: mem_a is left untouched, no RAM read issued.
              pc_q           <= ic_to_mc_pc;
              mc_to_ic_inst  <= lw_inst;
              mc_to_ic_ready <= 1'b1;
              state          <= RESP;
            end else
`endif
            begin
              pc_q  <= ic_to_mc_pc;
              mem_a <= wrap_addr(ic_to_mc_pc, 2'd0);
              state <= FETCH;
            end
          end
        end

        FETCH: begin
          if (!ic_to_mc_request || (ic_to_mc_pc != pc_q)) begin
            // Abort wins even on the byte3 edge; a new pc waits for IDLE.
            state     <= IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            asm_q     <= '0;
          end else begin
            // Addresses run one ahead of captures; the last one is held.
            if (issue_cnt != 2'd3) begin
              issue_cnt <= issue_cnt + 2'd1;
              mem_a     <= wrap_addr(pc_q, issue_cnt + 2'd1);
            end
            case (cap_cnt)
              3'd0: begin
                asm_q[7:0] <= mem_din;
                cap_cnt    <= 3'd1;
              end
              3'd1: begin
                asm_q[15:8] <= mem_din;
                cap_cnt     <= 3'd2;
              end
              3'd2: begin
                asm_q[23:16] <= mem_din;
                cap_cnt      <= 3'd3;
              end
              default: begin
                mc_to_ic_inst  <= {mem_din, asm_q};
                mc_to_ic_ready <= 1'b1;
                state          <= RESP;
                issue_cnt      <= '0;
                cap_cnt        <= '0;
`ifdef IFETCH_LAST_WORD_EN
                lw_valid       <= 1'b1;
                lw_pc          <= pc_q;
                lw_inst        <= {mem_din, asm_q};
`endif
              end
            endcase
          end
        end

        RESP: begin
          mc_to_ic_ready <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          mc_to_ic_ready <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
